// File: rtl/encoder_8x3_arb_pkg.sv
// Shared definitions for the 8:3 arbitrating encoder.
// Holds the controller state encoding, the lane count and the lane index width.
package encoder_8x3_arb_pkg;

  localparam int unsigned NUM_LANES = 8;
  localparam int unsigned IDX_W     = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

endpackage : encoder_8x3_arb_pkg

// File: rtl/encoder_8x3_arb_prio_enc.sv
// prio_enc_8x3: combinational priority encoder with a rotating start lane.
// Ports:
//   req   - per-lane request vector
//   start - lane at which the search begins (wraps 7 -> 0)
//   found - at least one request bit is set
//   idx   - first requesting lane at or after start
module prio_enc_8x3
  import encoder_8x3_arb_pkg::*;
(
  input  logic [NUM_LANES-1:0] req,
  input  logic [IDX_W-1:0]     start,
  output logic                 found,
  output logic [IDX_W-1:0]     idx
);

  logic [IDX_W-1:0] lane;

  // Walk from the farthest offset down to offset 0 so the nearest hit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    lane  = '0;
    for (int k = NUM_LANES - 1; k >= 0; k--) begin
      lane = start + IDX_W'(k);
      if (req[lane]) begin
        found = 1'b1;
        idx   = lane;
      end
    end
  end

endmodule : prio_enc_8x3

// File: rtl/encoder_8x3_arb.sv
// encoder_8x3_arb: captures one requesting lane's data per cycle into a
// single-word output register with valid/ready handshake.
// Lane selection is fixed priority (lowest index wins) by default, or
// round-robin when the macro ROUND_ROBIN_EN is defined.
// Ports:
//   clk, rst   - clock and synchronous active-high reset
//   en         - active-low enable (1 = no new captures)
//   req, din   - per-lane request and flattened lane data (lane i at [i*DW +: DW])
//   grant      - one-hot pulse naming the lane captured
//   dout       - captured lane data
//   out_idx    - binary index of the captured lane
//   out_valid  - dout/out_idx hold an unaccepted word
//   out_ready  - downstream accepts when out_valid && out_ready
module encoder_8x3_arb
  import encoder_8x3_arb_pkg::*;
#(
  parameter int unsigned DW = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [NUM_LANES-1:0]    req,
  input  logic [NUM_LANES*DW-1:0] din,
  output logic [NUM_LANES-1:0]    grant,
  output logic [DW-1:0]           dout,
  output logic [IDX_W-1:0]        out_idx,
  output logic                    out_valid,
  input  logic                    out_ready
);

  state_e                 state_q, state_d;
  logic [NUM_LANES-1:0]   grant_q, grant_d;
  logic [DW-1:0]          dout_q, dout_d;
  logic [IDX_W-1:0]       idx_q, idx_d;

  logic                   found;
  logic [IDX_W-1:0]       sel;
  logic [IDX_W-1:0]       start;
  logic                   eligible;
  logic                   capture;

`ifdef ROUND_ROBIN_EN
  logic [IDX_W-1:0]       last_idx_q, last_idx_d;

  // Search begins just past the most recently granted lane.
  assign start = last_idx_q + IDX_W'(1);
`else
  assign start = '0;
`endif

  prio_enc_8x3 u_prio_enc (
    .req   (req),
    .start (start),
    .found (found),
    .idx   (sel)
  );

  // Next-state and capture logic.
  always_comb begin
    state_d  = state_q;
    grant_d  = '0;
    dout_d   = dout_q;
    idx_d    = idx_q;
`ifdef ROUND_ROBIN_EN
    last_idx_d = last_idx_q;
`endif
    eligible = !en && found;
    // A slot is free in IDLE, or in HOLD when the held word is being accepted.
    capture  = eligible && ((state_q == ST_IDLE) || out_ready);

    case (state_q)
      ST_IDLE: if (eligible) state_d = ST_HOLD;
      ST_HOLD: if (out_ready) state_d = eligible ? ST_HOLD : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (capture) begin
      grant_d = NUM_LANES'(1) << sel;
      dout_d  = din[sel*DW +: DW];
      idx_d   = sel;
`ifdef ROUND_ROBIN_EN
      last_idx_d = sel;
`endif
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      dout_q  <= '0;
      idx_q   <= '0;
`ifdef ROUND_ROBIN_EN
      last_idx_q <= IDX_W'(NUM_LANES - 1);
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      dout_q  <= dout_d;
      idx_q   <= idx_d;
`ifdef ROUND_ROBIN_EN
      last_idx_q <= last_idx_d;
`endif
    end
  end

  assign grant     = grant_q;
  assign dout      = dout_q;
  assign out_idx   = idx_q;
  assign out_valid = (state_q == ST_HOLD);

endmodule : encoder_8x3_arb
